// File: rtl/cuart_baud_gen.sv
// Baud-rate tick generator: 16x-oversample strobe (baud_clock) and 1x bit strobe (xmit_pulse).
// Define CUART_BAUD_FRACTION_EN to compile in the fractional-divisor period stretch.
module cuart_baud_gen #(
    parameter int BAUD_W = 13,
    parameter int OVS_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              sync_clr,
    input  logic [BAUD_W-1:0] baud_val,
    input  logic [2:0]        baud_val_fraction,
    output logic              baud_clock,
    output logic              xmit_pulse
);

    logic [BAUD_W-1:0] cntr;
    logic [OVS_W-1:0]  ovs;
    logic              hold;
    logic              tick;

`ifdef CUART_BAUD_FRACTION_EN
    logic [2:0] acc;
    logic [3:0] acc_sum;

    // The carry out of the eighths accumulator marks a period that gets one extra cycle.
    assign acc_sum = {1'b0, acc} + {1'b0, baud_val_fraction};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc  <= '0;
            hold <= 1'b0;
        end else if (sync_clr) begin
            acc  <= '0;
            hold <= 1'b0;
        end else if (tick) begin
            acc  <= acc_sum[2:0];
            hold <= acc_sum[3];
        end else if (cntr == '0) begin
            hold <= 1'b0;
        end
    end
`else
    logic unused_fraction;

    assign hold            = 1'b0;
    assign unused_fraction = ^baud_val_fraction;
`endif

    assign tick = (cntr == '0) && !hold;

    // Divisor and fraction are only sampled at a reload, so a period in progress is never cut short.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cntr       <= '0;
            ovs        <= '0;
            baud_clock <= 1'b0;
            xmit_pulse <= 1'b0;
        end else if (sync_clr) begin
            cntr       <= '0;
            ovs        <= '0;
            baud_clock <= 1'b0;
            xmit_pulse <= 1'b0;
        end else if (tick) begin
            cntr       <= baud_val;
            ovs        <= ovs + 1'b1;
            baud_clock <= 1'b1;
            xmit_pulse <= (ovs == '1);
        end else begin
            if (cntr != '0) begin
                cntr <= cntr - 1'b1;
            end
            baud_clock <= 1'b0;
            xmit_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cuart_baud_gen.sv
// Self-checking bench for cuart_baud_gen: directed scenarios plus random segments checked against
// a tick-scheduling reference model (follows CUART_BAUD_FRACTION_EN if defined).
module tb_cuart_baud_gen;

    localparam int BAUD_W = 13;
    localparam int OVS_W  = 4;
`ifdef CUART_BAUD_FRACTION_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              sync_clr;
    logic [BAUD_W-1:0] baud_val;
    logic [2:0]        baud_val_fraction;
    logic              baud_clock;
    logic              xmit_pulse;

    cuart_baud_gen #(.BAUD_W(BAUD_W), .OVS_W(OVS_W)) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .sync_clr          (sync_clr),
        .baud_val          (baud_val),
        .baud_val_fraction (baud_val_fraction),
        .baud_clock        (baud_clock),
        .xmit_pulse        (xmit_pulse)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    // Reference model: absolute edge number of the next scheduled tick.
    int  edge_no    = 0;
    int  next_tick  = 1;
    int  tick_count = 0;
    int  frac_sum   = 0;
    bit  exp_bc     = 1'b0;
    bit  exp_xp     = 1'b0;

    int  base_edge      = 0;
    int  obs_ticks      = 0;
    int  first_tick_rel = -1;
    int  tick65_rel     = -1;
    int  first_xmit_rel = -1;

    task automatic checkOutput(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s observed=%b expected=%b edge=%0d", tag, obs, expv, edge_no);
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Called at each rising edge with the inputs the DUT sees at that edge.
    task automatic modelEdge();
        edge_no++;
        exp_bc = 1'b0;
        exp_xp = 1'b0;
        if (!RESET_N || sync_clr) begin
            next_tick  = edge_no + 1;
            tick_count = 0;
            frac_sum   = 0;
        end else if (edge_no == next_tick) begin
            int stretch;
            exp_bc     = 1'b1;
            tick_count = tick_count + 1;
            exp_xp     = (tick_count % 16) == 0;
            stretch    = 0;
            if (FRAC_EN) begin
                frac_sum = frac_sum + int'(baud_val_fraction);
                if (frac_sum >= 8) stretch = 1;
                frac_sum = frac_sum % 8;
            end
            next_tick = edge_no + int'(baud_val) + 1 + stretch;
        end
    endtask

    task automatic step();
        int rel;
        @(posedge CLK);
        modelEdge();
        #1;
        checkOutput("baud_clock", baud_clock, exp_bc);
        checkOutput("xmit_pulse", xmit_pulse, exp_xp);
        rel = edge_no - base_edge;
        if (baud_clock === 1'b1) begin
            obs_ticks++;
            if (obs_ticks == 1)  first_tick_rel = rel;
            if (obs_ticks == 65) tick65_rel = rel;
        end
        if (xmit_pulse === 1'b1 && first_xmit_rel < 0) first_xmit_rel = rel;
    endtask

    task automatic applyStimulus(input int n, input int f, input bit clr, input int cycles);
        baud_val          = BAUD_W'(n);
        baud_val_fraction = 3'(f);
        sync_clr          = clr;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic releaseReset();
        @(negedge CLK);
        RESET_N        = 1'b1;
        base_edge      = edge_no;
        obs_ticks      = 0;
        first_tick_rel = -1;
        tick65_rel     = -1;
        first_xmit_rel = -1;
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        #1;
        checkOutput("reset_bc", baud_clock, 1'b0);
        checkOutput("reset_xp", xmit_pulse, 1'b0);
        step();
        step();
        releaseReset();
    endtask

    initial begin
        RESET_N           = 1'b0;
        sync_clr          = 1'b0;
        baud_val          = BAUD_W'(3);
        baud_val_fraction = 3'd0;

        // Scenario 1: N=3, f=0 from power-on reset.
        step();
        step();
        checkOutput("por_bc", baud_clock, 1'b0);
        releaseReset();
        applyStimulus(3, 0, 1'b0, 130);
        checkValue("s1_first_tick", first_tick_rel, 1);
        checkValue("s1_first_xmit", first_xmit_rel, 61);

        // Scenario 2: N=3, f=4 -> 64 ticks span 288 cycles with fraction, 256 without.
        doReset();
        applyStimulus(3, 4, 1'b0, 300);
        checkValue("s2_64tick_span", tick65_rel - first_tick_rel, FRAC_EN ? 288 : 256);

        // Scenario 3: N=3, f=7.
        doReset();
        applyStimulus(3, 7, 1'b0, 60);

        // Scenario 4: N=0 with f=0 then f=4.
        doReset();
        applyStimulus(0, 0, 1'b0, 40);
        checkValue("s4_first_xmit", first_xmit_rel, 16);
        doReset();
        applyStimulus(0, 4, 1'b0, 20);

        // Scenario 5: divisor change mid-period, then sync_clr on a tick edge.
        doReset();
        applyStimulus(9, 0, 1'b0, 1);
        applyStimulus(4, 0, 1'b0, 30);
        for (int i = 0; i < 20 && (edge_no + 1) != next_tick; i++) step();
        applyStimulus(4, 0, 1'b1, 1);
        checkOutput("s5_clr_blocks_tick", baud_clock, 1'b0);
        applyStimulus(4, 0, 1'b0, 1);
        checkOutput("s5_clr_restart", baud_clock, 1'b1);
        applyStimulus(4, 0, 1'b0, 20);

        // Scenario 6: reset while baud_clock is high, then restart as scenario 1.
        doReset();
        applyStimulus(2, 0, 1'b0, 1);
        checkOutput("s6_pre_reset_bc", baud_clock, 1'b1);
        RESET_N = 1'b0;
        #1;
        checkOutput("s6_async_bc", baud_clock, 1'b0);
        checkOutput("s6_async_xp", xmit_pulse, 1'b0);
        step();
        baud_val = BAUD_W'(3);
        releaseReset();
        applyStimulus(3, 0, 1'b0, 70);
        checkValue("s6_first_tick", first_tick_rel, 1);
        checkValue("s6_first_xmit", first_xmit_rel, 61);

        // Random segments: divisor, fraction and occasional sync_clr.
        for (int s = 0; s < 40; s++) begin
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) == 0), int'($urandom_range(1, 20)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
